spi_bank_writer: RTL and testbench

System-clock-side write buffer directly downstream of the SPI slave. Accepts single-cycle write requests, already synchronized into `clk`, that target the block, row, CCL, weight or feature banks. Queues them in a small FIFO and issues them to the bank write ports under a ready/stall handshake. It also validates targets, counts completed writes and flags overflow and illegal targets with sticky error bits.

---
 rtl/spi_bank_writer.sv | 204 ++++++++++++++++++++
 tb/tb_spi_bank_writer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_bank_writer.sv
// Write buffer between the SPI slave and the configuration banks: queues validated
// write requests in a small FIFO and issues them one per cycle under bank_ready.
module spi_bank_writer #(
  parameter int N_PE_COL   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [2:0]                  req_target,
  input  logic [2:0]                  req_col,
  input  logic [11:0]                 req_addr,
  input  logic [31:0]                 req_data,
  input  logic                        en_conf,
  input  logic                        bank_ready,
  input  logic                        err_clr,
  output logic                        wen_block,
  output logic [N_PE_COL-1:0]         wen_row,
  output logic [N_PE_COL-1:0]         wen_ccl,
  output logic                        wen_weight,
  output logic                        wen_fe,
  output logic [11:0]                 wr_addr,
  output logic [31:0]                 wr_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_empty,
  output logic [15:0]                 wr_count,
  output logic                        err_overflow,
  output logic                        err_target
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [2:0]  target;
    logic [2:0]  col;
    logic [11:0] addr;
    logic [31:0] data;
  } entry_t;

  state_t              state_q, state_d;
  entry_t              mem_q [FIFO_DEPTH];
  entry_t              mem_d [FIFO_DEPTH];
  entry_t              head;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       fifo_count_q, fifo_count_d;
  logic                wen_block_q, wen_block_d;
  logic [N_PE_COL-1:0] wen_row_q, wen_row_d;
  logic [N_PE_COL-1:0] wen_ccl_q, wen_ccl_d;
  logic                wen_weight_q, wen_weight_d;
  logic                wen_fe_q, wen_fe_d;
  logic [11:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_target_q, err_target_d;
  logic                legal, full, empty, push, pop;

  always_comb begin
    legal = 1'b0;
    case (req_target)
      3'd0, 3'd3, 3'd4: legal = 1'b1;
      3'd1, 3'd2:       legal = (int'(req_col) < N_PE_COL);
      default:          legal = 1'b0;
    endcase
  end

  assign empty = (fifo_count_q == '0);
  assign full  = (fifo_count_q == CW'(FIFO_DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    wen_block_d  = wen_block_q;
    wen_row_d    = wen_row_q;
    wen_ccl_d    = wen_ccl_q;
    wen_weight_d = wen_weight_q;
    wen_fe_d     = wen_fe_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;

    // A pop always coincides with loading the head into the registered write port
    case (state_q)
      IDLE: begin
        if (!empty && en_conf) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bank_ready) begin
          wr_count_d = wr_count_q + 16'd1;
          if (!empty && en_conf) begin
            pop = 1'b1;
          end else begin
            state_d      = IDLE;
            wen_block_d  = 1'b0;
            wen_row_d    = '0;
            wen_ccl_d    = '0;
            wen_weight_d = 1'b0;
            wen_fe_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      wen_block_d  = (head.target == 3'd0);
      wen_row_d    = (head.target == 3'd1) ? (N_PE_COL'(1) << head.col) : '0;
      wen_ccl_d    = (head.target == 3'd2) ? (N_PE_COL'(1) << head.col) : '0;
      wen_weight_d = (head.target == 3'd3);
      wen_fe_d     = (head.target == 3'd4);
      wr_addr_d    = head.addr;
      wr_data_d    = head.data;
    end
  end

  always_comb begin
    push         = req_valid && legal && (!full || pop);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{target: req_target, col: req_col, addr: req_addr, data: req_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // New error events take priority over a same-cycle clear
    err_target_d   = err_target_q;
    err_overflow_d = err_overflow_q;
    if (err_clr) begin
      err_target_d   = 1'b0;
      err_overflow_d = 1'b0;
    end
    if (req_valid && !legal) begin
      err_target_d = 1'b1;
    end
    if (req_valid && legal && !push) begin
      err_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      wen_block_q    <= 1'b0;
      wen_row_q      <= '0;
      wen_ccl_q      <= '0;
      wen_weight_q   <= 1'b0;
      wen_fe_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_count_q     <= '0;
      err_overflow_q <= 1'b0;
      err_target_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      wen_block_q    <= wen_block_d;
      wen_row_q      <= wen_row_d;
      wen_ccl_q      <= wen_ccl_d;
      wen_weight_q   <= wen_weight_d;
      wen_fe_q       <= wen_fe_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_count_q     <= wr_count_d;
      err_overflow_q <= err_overflow_d;
      err_target_q   <= err_target_d;
    end
  end

  assign wen_block    = wen_block_q;
  assign wen_row      = wen_row_q;
  assign wen_ccl      = wen_ccl_q;
  assign wen_weight   = wen_weight_q;
  assign wen_fe       = wen_fe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign fifo_count   = fifo_count_q;
  assign fifo_empty   = empty;
  assign wr_count     = wr_count_q;
  assign err_overflow = err_overflow_q;
  assign err_target   = err_target_q;

endmodule

// File: tb/tb_spi_bank_writer.sv
// Scoreboard bench for spi_bank_writer: stimulus queues expected writes, a negedge
// monitor compares every presented write against the queue head.
module tb_spi_bank_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_target;
  logic [2:0]  req_col;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic        en_conf;
  logic        bank_ready;
  logic        err_clr;
  logic        wen_block;
  logic [4:0]  wen_row;
  logic [4:0]  wen_ccl;
  logic        wen_weight;
  logic        wen_fe;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;
  logic        fifo_empty;
  logic [15:0] wr_count;
  logic        err_overflow;
  logic        err_target;

  int total = 0;
  int bad   = 0;

  // Expected write: {block, row[4:0], ccl[4:0], weight, fe, addr, data}
  logic [56:0] exp_q [$];
  logic [12:0] mon_en;

  spi_bank_writer #(.N_PE_COL(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_target(req_target),
    .req_col(req_col), .req_addr(req_addr), .req_data(req_data),
    .en_conf(en_conf), .bank_ready(bank_ready), .err_clr(err_clr),
    .wen_block(wen_block), .wen_row(wen_row), .wen_ccl(wen_ccl),
    .wen_weight(wen_weight), .wen_fe(wen_fe), .wr_addr(wr_addr),
    .wr_data(wr_data), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .wr_count(wr_count), .err_overflow(err_overflow), .err_target(err_target)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] t, input logic [2:0] c, input logic [11:0] a,
                               input logic [31:0] d, input logic [12:0] exp_en, input bit exp_push);
    req_valid  = 1'b1;
    req_target = t;
    req_col    = c;
    req_addr   = a;
    req_data   = d;
    if (exp_push) exp_q.push_back({exp_en, a, d});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare any presented write against the queue head; pop when it completes
  always @(negedge clk) begin
    if (!rst) begin
      mon_en = {wen_block, wen_row, wen_ccl, wen_weight, wen_fe};
      if (mon_en != 13'd0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 64'({mon_en, wr_addr, wr_data}), 64'd0);
        end else begin
          checkOutput("write", 64'({mon_en, wr_addr, wr_data}), 64'(exp_q[0]));
          if (bank_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_target = '0; req_col = '0; req_addr = '0;
    req_data = '0; en_conf = 1'b0; bank_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_outputs", 64'({wen_block, wen_row, wen_ccl, wen_weight, wen_fe, wr_addr, wr_data}), 64'd0);
    checkOutput("reset_count", 64'({fifo_count, wr_count, err_overflow, err_target}), 64'd0);
    checkOutput("reset_empty", 64'(fifo_empty), 64'd1);
    rst = 1'b0;

    $display("[TB] single write");
    en_conf = 1'b1; bank_ready = 1'b1;
    applyStimulus(3'd3, 3'd0, 12'h055, 32'hDEADBEEF, 13'h0002, 1'b1);
    checkOutput("single_count_n1", 64'(fifo_count), 64'd1);
    checkOutput("single_wen_n1", 64'(wen_weight), 64'd0);
    @(posedge clk); #1;
    checkOutput("single_wen_n2", 64'(wen_weight), 64'd1);
    checkOutput("single_addr_n2", 64'(wr_addr), 64'h055);
    checkOutput("single_data_n2", 64'(wr_data), 64'hDEADBEEF);
    @(posedge clk); #1;
    checkOutput("single_wen_n3", 64'(wen_weight), 64'd0);
    checkOutput("single_wr_count", 64'(wr_count), 64'd1);
    checkOutput("single_empty", 64'(fifo_empty), 64'd1);

    $display("[TB] row/ccl column select");
    doReset();
    applyStimulus(3'd1, 3'd4, 12'h0A1, 32'h11111111, 13'h0800, 1'b1);
    applyStimulus(3'd2, 3'd0, 12'h0A2, 32'h22222222, 13'h0004, 1'b1);
    checkOutput("row_onehot", 64'(wen_row), 64'b10000);
    @(posedge clk); #1;
    checkOutput("ccl_onehot", 64'(wen_ccl), 64'b00001);
    checkOutput("row_cleared", 64'(wen_row), 64'd0);
    waitDrain();
    checkOutput("rowccl_wr_count", 64'(wr_count), 64'd2);

    $display("[TB] illegal targets");
    doReset();
    applyStimulus(3'd6, 3'd0, 12'h0B0, 32'h0, 13'h0000, 1'b0);
    applyStimulus(3'd1, 3'd5, 12'h0B1, 32'h0, 13'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("illegal_fifo", 64'(fifo_count), 64'd0);
    checkOutput("illegal_err_target", 64'(err_target), 64'd1);
    checkOutput("illegal_err_overflow", 64'(err_overflow), 64'd0);
    checkOutput("illegal_wr_count", 64'(wr_count), 64'd0);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    checkOutput("err_clr", 64'(err_target), 64'd0);
    err_clr = 1'b1;
    applyStimulus(3'd7, 3'd0, 12'h0B2, 32'h0, 13'h0000, 1'b0);
    err_clr = 1'b0;
    checkOutput("err_set_wins", 64'(err_target), 64'd1);

    $display("[TB] stall");
    doReset();
    applyStimulus(3'd4, 3'd0, 12'h0C0, 32'hC0C0C0C0, 13'h0001, 1'b1);
    applyStimulus(3'd2, 3'd3, 12'h0C1, 32'hC1C1C1C1, 13'h0020, 1'b1);
    bank_ready = 1'b0;
    checkOutput("stall_hold_0", 64'({wen_fe, wr_addr, wr_data}), 64'({1'b1, 12'h0C0, 32'hC0C0C0C0}));
    applyStimulus(3'd1, 3'd1, 12'h0C2, 32'hC2C2C2C2, 13'h0100, 1'b1);
    checkOutput("stall_hold_1", 64'({wen_fe, wr_addr, wr_data}), 64'({1'b1, 12'h0C0, 32'hC0C0C0C0}));
    for (int i = 2; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall_hold_%0d", i), 64'({wen_fe, wr_addr, wr_data}), 64'({1'b1, 12'h0C0, 32'hC0C0C0C0}));
    end
    checkOutput("stall_wr_count", 64'(wr_count), 64'd0);
    bank_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_second", 64'({wen_fe, wen_ccl, wr_addr}), 64'({1'b0, 5'b01000, 12'h0C1}));
    @(posedge clk); #1;
    checkOutput("stall_third", 64'({wen_row, wr_addr}), 64'({5'b00010, 12'h0C2}));
    waitDrain();
    checkOutput("stall_total", 64'(wr_count), 64'd3);

    $display("[TB] overflow");
    doReset();
    en_conf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'd4, 3'd0, 12'(12'h100 + i), 32'(32'hA0 + i), 13'h0001, i < 4);
    end
    checkOutput("ovf_fifo_full", 64'(fifo_count), 64'd4);
    checkOutput("ovf_err", 64'(err_overflow), 64'd1);
    checkOutput("ovf_no_write", 64'(wr_count), 64'd0);
    en_conf = 1'b1;
    applyStimulus(3'd3, 3'd0, 12'h200, 32'h000055AA, 13'h0002, 1'b1);
    checkOutput("full_push_pop", 64'(fifo_count), 64'd4);
    waitDrain();
    checkOutput("ovf_drained", 64'(wr_count), 64'd5);
    checkOutput("ovf_empty", 64'(fifo_empty), 64'd1);
    checkOutput("ovf_sticky", 64'(err_overflow), 64'd1);

    $display("[TB] reset mid-burst");
    doReset();
    bank_ready = 1'b0;
    applyStimulus(3'd0, 3'd0, 12'h010, 32'h1, 13'h1000, 1'b1);
    applyStimulus(3'd4, 3'd0, 12'h011, 32'h2, 13'h0001, 1'b1);
    applyStimulus(3'd1, 3'd1, 12'h012, 32'h3, 13'h0100, 1'b1);
    checkOutput("burst_queued", 64'(fifo_count), 64'd2);
    checkOutput("burst_issue", 64'(wen_block), 64'd1);
    doReset();
    checkOutput("midrst_outputs", 64'({wen_block, wen_row, wen_ccl, wen_weight, wen_fe, wr_addr, wr_data}), 64'd0);
    checkOutput("midrst_empty", 64'(fifo_empty), 64'd1);
    checkOutput("midrst_counts", 64'({fifo_count, wr_count, err_overflow, err_target}), 64'd0);
    bank_ready = 1'b1;
    applyStimulus(3'd3, 3'd0, 12'h3FF, 32'h12345678, 13'h0002, 1'b1);
    waitDrain();
    checkOutput("midrst_after", 64'(wr_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
